// File: rtl/mips_ctl_pkg.sv
// Shared definitions for the multi-cycle MIPS main control FSM.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: FSM state enum, opcode constants, ALUOp / PCSource / ALUSrcB encodings,
// and the packed control word the FSM decodes each cycle.
package mips_ctl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXEC_R   = 4'd6,
        S_RTYPE_WB = 4'd7,
        S_EXEC_I   = 4'd8,
        S_ITYPE_WB = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // One cycle's worth of datapath control, plus the retire pulse.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic [1:0] alu_src_b;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
        logic       retire;
    } ctl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Bundle between the main control FSM and the multi-cycle datapath/memory.
// Latency: n/a (wires only).
// Backpressure: MemReady from memory stalls the FSM in its memory-access states.
// Ports: master = control FSM (drives controls, status); slave = datapath side.
interface multicycle_control_if #(
    parameter int OP_W         = 6,
    parameter int RETIRE_CNT_W = 16
);
    logic [OP_W-1:0]         Opcode;
    logic                    Zero;
    logic                    MemReady;
    logic                    PCWrite;
    logic                    PCWriteCond;
    logic                    IorD;
    logic                    MemRead;
    logic                    MemWrite;
    logic                    MemtoReg;
    logic                    IRWrite;
    logic [1:0]              PCSource;
    logic [1:0]              ALUOp;
    logic [1:0]              ALUSrcB;
    logic                    ALUSrcA;
    logic                    RegWrite;
    logic                    RegDst;
    logic                    Retire;
    logic                    Illegal;
    logic [RETIRE_CNT_W-1:0] RetireCount;

    modport master (
        input  Opcode, Zero, MemReady,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
               PCSource, ALUOp, ALUSrcB, ALUSrcA, RegWrite, RegDst,
               Retire, Illegal, RetireCount
    );

    modport slave (
        output Opcode, Zero, MemReady,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
               PCSource, ALUOp, ALUSrcB, ALUSrcA, RegWrite, RegDst,
               Retire, Illegal, RetireCount
    );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath; counts retired and flags illegal opcodes.
// Latency: controls are combinational from state (+MemReady); LW 5, SW/R/ADDI 4, BEQ/J 3 cycles.
// Backpressure: holds in FETCH/MEMRD/MEMWR with request held steady until MemReady.
// Ports: clk, rst_n (async active-low); ctl_if.master carries Opcode/Zero/MemReady in and
// all datapath controls, Retire, Illegal and RetireCount out.
module multicycle_control
    import mips_ctl_pkg::*;
#(
    parameter int OP_W         = 6,
    parameter int RETIRE_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_control_if.master ctl_if
);

    state_t                  r_state;
    state_t                  w_next;
    ctl_t                    w_ctl;
    logic                    w_set_illegal;
    logic                    r_illegal;
    logic [RETIRE_CNT_W-1:0] r_retire_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_FETCH;
            r_illegal    <= 1'b0;
            r_retire_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (w_set_illegal)
                r_illegal <= 1'b1;
            if (w_ctl.retire)
                r_retire_cnt <= r_retire_cnt + RETIRE_CNT_W'(1);
        end
    end

    always_comb begin
        w_ctl         = '0;
        w_next        = S_FETCH;
        w_set_illegal = 1'b0;
        unique case (r_state)
            S_FETCH: begin
                // PC += 4 and IR load happen only on the cycle memory delivers the word.
                w_ctl.mem_read  = 1'b1;
                w_ctl.alu_src_b = SRCB_FOUR;
                w_ctl.alu_op    = ALUOP_ADD;
                w_ctl.pc_source = PCSRC_ALU;
                w_ctl.ir_write  = ctl_if.MemReady;
                w_ctl.pc_write  = ctl_if.MemReady;
                w_next          = ctl_if.MemReady ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // Speculatively compute the branch target into ALUOut.
                w_ctl.alu_src_b = SRCB_IMM_SH2;
                w_ctl.alu_op    = ALUOP_ADD;
                case (ctl_if.Opcode)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_R:         w_next = S_EXEC_R;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_J:         w_next = S_JUMP;
                    OP_ADDI:      w_next = S_EXEC_I;
                    default: begin
                        w_next        = S_FETCH;
                        w_set_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                w_ctl.alu_src_a = 1'b1;
                w_ctl.alu_src_b = SRCB_IMM;
                w_ctl.alu_op    = ALUOP_ADD;
                w_next          = (ctl_if.Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                w_ctl.mem_read = 1'b1;
                w_ctl.iord     = 1'b1;
                w_next         = ctl_if.MemReady ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                w_ctl.reg_write  = 1'b1;
                w_ctl.mem_to_reg = 1'b1;
                w_ctl.retire     = 1'b1;
            end
            S_MEMWR: begin
                w_ctl.mem_write = 1'b1;
                w_ctl.iord      = 1'b1;
                w_ctl.retire    = ctl_if.MemReady;
                w_next          = ctl_if.MemReady ? S_FETCH : S_MEMWR;
            end
            S_EXEC_R: begin
                w_ctl.alu_src_a = 1'b1;
                w_ctl.alu_src_b = SRCB_B;
                w_ctl.alu_op    = ALUOP_FUNCT;
                w_next          = S_RTYPE_WB;
            end
            S_RTYPE_WB: begin
                w_ctl.reg_write = 1'b1;
                w_ctl.reg_dst   = 1'b1;
                w_ctl.retire    = 1'b1;
            end
            S_EXEC_I: begin
                w_ctl.alu_src_a = 1'b1;
                w_ctl.alu_src_b = SRCB_IMM;
                w_ctl.alu_op    = ALUOP_ADD;
                w_next          = S_ITYPE_WB;
            end
            S_ITYPE_WB: begin
                w_ctl.reg_write = 1'b1;
                w_ctl.retire    = 1'b1;
            end
            S_BRANCH: begin
                w_ctl.alu_src_a     = 1'b1;
                w_ctl.alu_src_b     = SRCB_B;
                w_ctl.alu_op        = ALUOP_SUB;
                w_ctl.pc_write_cond = 1'b1;
                w_ctl.pc_source     = PCSRC_ALUOUT;
                w_ctl.retire        = 1'b1;
            end
            S_JUMP: begin
                w_ctl.pc_write  = 1'b1;
                w_ctl.pc_source = PCSRC_JUMP;
                w_ctl.retire    = 1'b1;
            end
            default: begin
                // Unused encodings: all controls idle, recover to FETCH.
                w_ctl  = '0;
                w_next = S_FETCH;
            end
        endcase
    end

    // Controls are gated by rst_n so they drop to zero the instant reset asserts.
    assign ctl_if.PCWrite     = rst_n & w_ctl.pc_write;
    assign ctl_if.PCWriteCond = rst_n & w_ctl.pc_write_cond;
    assign ctl_if.IorD        = rst_n & w_ctl.iord;
    assign ctl_if.MemRead     = rst_n & w_ctl.mem_read;
    assign ctl_if.MemWrite    = rst_n & w_ctl.mem_write;
    assign ctl_if.MemtoReg    = rst_n & w_ctl.mem_to_reg;
    assign ctl_if.IRWrite     = rst_n & w_ctl.ir_write;
    assign ctl_if.PCSource    = {2{rst_n}} & w_ctl.pc_source;
    assign ctl_if.ALUOp       = {2{rst_n}} & w_ctl.alu_op;
    assign ctl_if.ALUSrcB     = {2{rst_n}} & w_ctl.alu_src_b;
    assign ctl_if.ALUSrcA     = rst_n & w_ctl.alu_src_a;
    assign ctl_if.RegWrite    = rst_n & w_ctl.reg_write;
    assign ctl_if.RegDst      = rst_n & w_ctl.reg_dst;
    assign ctl_if.Retire      = rst_n & w_ctl.retire;
    assign ctl_if.Illegal     = r_illegal;
    assign ctl_if.RetireCount = r_retire_cnt;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multi-cycle MIPS datapath: sequences PC, instruction register, memory, register file and ALU across fetch/decode/execute/memory/writeback steps.
- Decodes the 6-bit opcode and drives the 2-bit ALUOp consumed by the existing ALU control decoder, which turns ALUOp plus funct into the 4-bit ALU control.
- Stalls on a memory ready handshake.
- Reports retired and illegal instructions.

Parameters:
- OP_W, 6, opcode width.
- RETIRE_CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- Opcode  input  OP_W  instruction register bits [31:26].
- Zero  input  1  ALU zero flag.
- MemReady  input  1  memory has completed the current access this cycle.
- PCWrite  output  1  unconditional PC load.
- PCWriteCond  output  1  PC load if Zero.
- IorD  output  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  output  1  memory read request.
- MemWrite  output  1  memory write request.
- MemtoReg  output  1  write-back select: 1 = MDR.
- IRWrite  output  1  load instruction register.
- PCSource  output  2  next-PC select: 00 = ALU, 01 = ALUOut, 10 = jump target.
- ALUOp  output  2  00 = add, 01 = sub, 10 = use funct.
- ALUSrcB  output  2  00 = B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2.
- ALUSrcA  output  1  0 = PC, 1 = A.
- RegWrite  output  1  register file write.
- RegDst  output  1  1 = rd, 0 = rt.
- Retire  output  1  one-cycle pulse on instruction completion.
- Illegal  output  1  sticky unknown-opcode flag.
- RetireCount  output  RETIRE_CNT_W  retired-instruction count.

Behaviour:
- Reset: asynchronous, active low. State <= FETCH, Illegal <= 0, RetireCount <= 0.
- While rst_n = 0, every control output and Retire are forced to 0.
- Control outputs are a combinational decode of the state register and MemReady. All state changes occur on the rising clk edge.
- Opcodes: R = 000000, LW = 100011, SW = 101011, BEQ = 000100, J = 000010, ADDI = 001000.
- FETCH: MemRead = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALUOp = 00, PCSource = 00. IRWrite = PCWrite = MemReady. Advance to DECODE only when MemReady = 1; otherwise hold with no PC or IR update.
- DECODE: ALUSrcA = 0, ALUSrcB = 11, ALUOp = 00 (branch target into ALUOut). Next state by opcode:
  - LW or SW -> MEMADR
  - R -> EXEC_R
  - BEQ -> BRANCH
  - J -> JUMP
  - ADDI -> EXEC_I
  - anything else -> FETCH with Illegal set; no Retire.
- MEMADR: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00. Next: LW -> MEMRD, SW -> MEMWR.
- MEMRD: MemRead = 1, IorD = 1. Hold until MemReady, then -> MEMWB.
- MEMWB: RegWrite = 1, MemtoReg = 1, RegDst = 0. Retire. -> FETCH.
- MEMWR: MemWrite = 1, IorD = 1. Hold until MemReady; then Retire and -> FETCH.
- EXEC_R: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 10. -> RTYPE_WB.
- RTYPE_WB: RegWrite = 1, RegDst = 1, MemtoReg = 0. Retire. -> FETCH.
- EXEC_I: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00. -> ITYPE_WB.
- ITYPE_WB: RegWrite = 1, RegDst = 0, MemtoReg = 0. Retire. -> FETCH.
- BRANCH: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 01, PCWriteCond = 1, PCSource = 01. Retire. -> FETCH.
- JUMP: PCWrite = 1, PCSource = 10. Retire. -> FETCH.
- Any output not listed for a state is 0.
- Cycle counts with MemReady tied high: LW 5, SW 4, R 4, ADDI 4, BEQ 3, J 3.
- MemRead and MemWrite hold steady for the whole wait. The Opcode input must stay stable after DECODE (the IR is loaded only in FETCH).
- Retire increments RetireCount, wrapping modulo 2^RETIRE_CNT_W.
- Illegal clears only on reset.
- Unreachable state encodings go to FETCH with all outputs 0.
- Reset asserted mid-instruction aborts immediately. The first cycle after release is FETCH.

Decomposition:
- Shared package mips_ctl_pkg holds:
  - the state enum
  - opcode constants
  - ALUOp codes (ADD/SUB/FUNCT)
  - PCSource and ALUSrcB encodings
- Single module; a sub-module is not needed. The ALU control decoder stays separate, fed by ALUOp.

Test Plan:
- Reset then an R-type, Opcode = 000000, MemReady = 1 -> states FETCH, DECODE, EXEC_R, RTYPE_WB. ALUOp = 10 in EXEC_R; RegWrite = 1 and RegDst = 1 in cycle 4; Retire pulses once; RetireCount = 1.
- LW with MemReady low for 3 cycles in FETCH and 2 in MEMRD -> 10 cycles total. IRWrite and PCWrite only on the ready cycle; MemRead held high throughout each wait; MemtoReg = 1 in MEMWB.
- BEQ with Zero = 1, then BEQ with Zero = 0 -> PCWriteCond = 1, PCSource = 01, ALUOp = 01 in cycle 3 of each; 3 cycles each; RetireCount += 2.
- Opcode = 111111 -> DECODE returns to FETCH; Illegal = 1 and stays set through a following J (PCWrite = 1, PCSource = 10); no Retire for the illegal instruction.
- rst_n pulled low during MEMWR while waiting -> all outputs 0 at once, RetireCount = 0. After release, FETCH with MemRead = 1.
- RETIRE_CNT_W = 4, 17 J instructions -> RetireCount wraps to 1.
